// File: rtl/sample_mem_ctrl.sv
// rtl/sample_mem_ctrl.sv - capture one frame of samples into a RAM, then serve reads until released
// Optional OVERRUN_CNT_EN adds a saturating count of samples arriving while a frame is held.
module sample_mem_ctrl #(
  parameter int DATA_W    = 10,
  parameter int ADDR_W    = 11,
  parameter int FRAME_LEN = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_done,
  output logic              busy,
`ifdef OVERRUN_CNT_EN
  output logic              frame_ready,
  output logic [15:0]       overrun_cnt
`else
  output logic              frame_ready
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_LEN - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_rd_pend;
  logic              r_rd_valid;
  logic              r_busy;
  logic              r_frame_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_we      <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_ready <= 1'b0;
    end else begin
      r_mem_we   <= 1'b0;
      r_rd_pend  <= 1'b0;
      // Read pipeline runs independent of state so a read issued with rd_done still completes.
      r_rd_valid <= r_rd_pend;
      case (r_state)
        S_IDLE: begin
          r_mem_addr <= '0;
          if (start) begin
            r_state  <= S_FILL;
            r_wr_ptr <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_FILL: begin
          if (smp_valid) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_wr_ptr;
            r_mem_wdata <= smp_data;
            r_wr_ptr    <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == LAST_PTR) begin
              r_state       <= S_READY;
              r_busy        <= 1'b0;
              r_frame_ready <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (rd_req) begin
            r_mem_addr <= rd_addr;
            r_rd_pend  <= 1'b1;
          end
          if (rd_done) begin
            r_state       <= S_IDLE;
            r_frame_ready <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
          r_frame_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef OVERRUN_CNT_EN
  logic [15:0] r_overrun_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun_cnt <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_overrun_cnt <= '0;
    end else if (r_state == S_READY && smp_valid && r_overrun_cnt != 16'hFFFF) begin
      r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end
  end

  assign overrun_cnt = r_overrun_cnt;
`endif

  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_we      = r_mem_we;
  assign rd_data     = mem_rdata;
  assign rd_valid    = r_rd_valid;
  assign busy        = r_busy;
  assign frame_ready = r_frame_ready;

endmodule

// File: tb/tb_sample_mem_ctrl.sv
// tb/tb_sample_mem_ctrl.sv - directed bench for sample_mem_ctrl with FRAME_LEN=8 and a behavioural RAM
// Build with OVERRUN_CNT_EN defined to also exercise the overrun counter.
module tb_sample_mem_ctrl;
  localparam int DATA_W    = 10;
  localparam int ADDR_W    = 11;
  localparam int FRAME_LEN = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              smp_valid;
  logic [DATA_W-1:0] smp_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_done;
  logic              busy;
  logic              frame_ready;
`ifdef OVERRUN_CNT_EN
  logic [15:0]       overrun_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wa_q [$];
  logic [DATA_W-1:0] wd_q [$];
  logic [DATA_W-1:0] rv_q [$];
  int                rc_q [$];

  sample_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid), .smp_data(smp_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_done(rd_done), .busy(busy),
`ifdef OVERRUN_CNT_EN
    .frame_ready(frame_ready), .overrun_cnt(overrun_cnt)
`else
    .frame_ready(frame_ready)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Log every write and every read return just after the edge that produced it.
  always begin
    @(posedge clk);
    #1;
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (rd_valid) begin
      rv_q.push_back(rd_data);
      rc_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    rv_q.delete();
    rc_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0b want=0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%0d want=0", mem_addr); end
    total++; if (mem_wdata !== '0) begin bad++; $display("FAIL reset_mem_wdata got=%0d want=0", mem_wdata); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b want=0", rd_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL reset_frame_ready got=%0b want=0", frame_ready); end
  endtask

  task automatic test_fill();
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fill_busy got=%0b want=1", busy); end
    for (int i = 0; i < FRAME_LEN; i++) begin
      smp_valid = 1'b1;
      smp_data  = DATA_W'(i + 1);
      step();
    end
    smp_valid = 1'b0;
    total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL fill_frame_ready got=%0b want=1", frame_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fill_busy_done got=%0b want=0", busy); end
    total++; if (mem_we !== 1'b1 || mem_addr !== 11'd7 || mem_wdata !== 10'd8)
      begin bad++; $display("FAIL fill_last_write got=we%0b a%0d d%0d want=we1 a7 d8", mem_we, mem_addr, mem_wdata); end
    step();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL fill_we_idle got=%0b want=0", mem_we); end
    total++; if (wa_q.size() != FRAME_LEN) begin bad++; $display("FAIL fill_count got=%0d want=8", wa_q.size()); end
    for (int i = 0; i < FRAME_LEN; i++) begin
      total++;
      if (i >= wa_q.size() || wa_q[i] !== ADDR_W'(i) || wd_q[i] !== DATA_W'(i + 1)) begin
        bad++;
        $display("FAIL fill_write_%0d got=a%0d d%0d want=a%0d d%0d", i,
                 (i < wa_q.size()) ? wa_q[i] : 'x, (i < wd_q.size()) ? wd_q[i] : 'x, i, i + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int req_cyc;
    clear_logs();
    req_cyc = cyc;
    rd_req = 1'b1; rd_addr = 11'd3;
    step();
    rd_addr = 11'd5;
    step();
    rd_req = 1'b0;
    step(); step(); step();
    total++; if (rv_q.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", rv_q.size()); end
    if (rv_q.size() == 2) begin
      total++; if (rv_q[0] !== 10'd4 || rc_q[0] != req_cyc + 2)
        begin bad++; $display("FAIL b2b_first got=d%0d c%0d want=d4 c%0d", rv_q[0], rc_q[0], req_cyc + 2); end
      total++; if (rv_q[1] !== 10'd6 || rc_q[1] != req_cyc + 3)
        begin bad++; $display("FAIL b2b_second got=d%0d c%0d want=d6 c%0d", rv_q[1], rc_q[1], req_cyc + 3); end
    end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL b2b_no_write got=%0b want=0", mem_we); end
  endtask

  task automatic test_rd_done();
    int req_cyc;
    clear_logs();
    req_cyc = cyc;
    rd_req = 1'b1; rd_addr = 11'd0; rd_done = 1'b1;
    step();
    rd_req = 1'b0; rd_done = 1'b0;
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL done_frame_ready got=%0b want=0", frame_ready); end
    step(); step();
    total++; if (rv_q.size() != 1) begin bad++; $display("FAIL done_read_count got=%0d want=1", rv_q.size()); end
    if (rv_q.size() == 1) begin
      total++; if (rv_q[0] !== 10'd1 || rc_q[0] != req_cyc + 2)
        begin bad++; $display("FAIL done_read got=d%0d c%0d want=d1 c%0d", rv_q[0], rc_q[0], req_cyc + 2); end
    end
    total++; if (busy !== 1'b0 || mem_addr !== '0)
      begin bad++; $display("FAIL done_idle got=busy%0b a%0d want=busy0 a0", busy, mem_addr); end
    clear_logs();
    rd_req = 1'b1; rd_addr = 11'd2;
    step();
    rd_req = 1'b0;
    step(); step(); step();
    total++; if (rv_q.size() != 0) begin bad++; $display("FAIL idle_rd_req got=%0d want=0", rv_q.size()); end
  endtask

  task automatic test_ignore();
    clear_logs();
    smp_valid = 1'b1; smp_data = 10'h55;
    step();
    smp_valid = 1'b0;
    step();
    total++; if (wa_q.size() != 0) begin bad++; $display("FAIL idle_sample_write got=%0d want=0", wa_q.size()); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp_valid = 1'b1; smp_data = DATA_W'(10 + i);
      step();
    end
    smp_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 3; i < FRAME_LEN; i++) begin
      smp_valid = 1'b1; smp_data = DATA_W'(10 + i);
      step();
    end
    smp_valid = 1'b0;
    step();
    total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL ignore_frame_ready got=%0b want=1", frame_ready); end
    total++; if (wa_q.size() != FRAME_LEN) begin bad++; $display("FAIL ignore_count got=%0d want=8", wa_q.size()); end
    for (int i = 0; i < FRAME_LEN; i++) begin
      total++;
      if (i >= wa_q.size() || wa_q[i] !== ADDR_W'(i) || wd_q[i] !== DATA_W'(10 + i)) begin
        bad++;
        $display("FAIL ignore_write_%0d got=a%0d d%0d want=a%0d d%0d", i,
                 (i < wa_q.size()) ? wa_q[i] : 'x, (i < wd_q.size()) ? wd_q[i] : 'x, i, 10 + i);
      end
    end
  endtask

`ifdef OVERRUN_CNT_EN
  task automatic test_overrun();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      smp_valid = 1'b1; smp_data = DATA_W'(100 + i);
      step();
    end
    smp_valid = 1'b0;
    step();
    total++; if (overrun_cnt !== 16'd3) begin bad++; $display("FAIL overrun_cnt got=%0d want=3", overrun_cnt); end
    total++; if (wa_q.size() != 0) begin bad++; $display("FAIL overrun_writes got=%0d want=0", wa_q.size()); end
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (overrun_cnt !== 16'd0) begin bad++; $display("FAIL overrun_clear got=%0d want=0", overrun_cnt); end
  endtask
`endif

  task automatic test_reset_mid();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp_valid = 1'b1; smp_data = DATA_W'(20 + i);
      step();
    end
    smp_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0b want=1", busy); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if (busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || frame_ready !== 1'b0)
      begin bad++; $display("FAIL mid_reset got=busy%0b we%0b a%0d fr%0b want=0 0 0 0", busy, mem_we, mem_addr, frame_ready); end
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      smp_valid = 1'b1; smp_data = DATA_W'(30 + i);
      step();
    end
    smp_valid = 1'b0;
    step();
    total++; if (wa_q.size() != FRAME_LEN) begin bad++; $display("FAIL restart_count got=%0d want=8", wa_q.size()); end
    for (int i = 0; i < FRAME_LEN; i++) begin
      total++;
      if (i >= wa_q.size() || wa_q[i] !== ADDR_W'(i) || wd_q[i] !== DATA_W'(30 + i)) begin
        bad++;
        $display("FAIL restart_write_%0d got=a%0d d%0d want=a%0d d%0d", i,
                 (i < wa_q.size()) ? wa_q[i] : 'x, (i < wd_q.size()) ? wd_q[i] : 'x, i, 30 + i);
      end
    end
    clear_logs();
    rd_req = 1'b1; rd_addr = 11'd1;
    step();
    rd_req = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step(); step();
    total++; if (rv_q.size() != 0) begin bad++; $display("FAIL reset_pending_read got=%0d want=0", rv_q.size()); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_drop got=%0b want=0", frame_ready); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; smp_valid = 1'b0; smp_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_back_to_back();
    test_rd_done();
    test_ignore();
`ifdef OVERRUN_CNT_EN
    test_overrun();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
